inst_rom_loader: RTL and testbench

//   Instruction-memory responder for the core fetch port (inst_en/inst_addr -> inst).

---
 rtl/inst_rom_loader.sv | 110 +++++++++++
 tb/tb_inst_rom_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// Instruction ROM/RAM with a same-cycle combinational fetch, filled by a byte-stream boot loader.
// The loader takes one byte per cycle when ready; fetch returns NOP for the whole load session.
module inst_rom_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h1c000000,
    parameter logic [31:0] NOP_INST  = 32'h03400000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_en_i,
    input  logic [31:0]       inst_addr_i,
    output logic [31:0]       inst_o,
    input  logic              load_start_i,
    input  logic              load_valid_i,
    input  logic [7:0]        load_byte_i,
    output logic              load_ready_o,
    output logic              load_busy_o,
    output logic              load_done_o,
    output logic              load_err_o,
    output logic [ADDR_W:0]   words_loaded_o
);
    localparam int          DEPTH   = 2**ADDR_W;
    localparam logic [31:0] DEPTH32 = 32'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;

    state_t       r_state;
    state_t       w_next;
    logic [1:0]   r_byte_cnt;
    logic [23:0]  r_shift;
    logic [31:0]  r_count;
    logic [31:0]  r_rcvd;
    logic         r_err;
    logic [31:0]  r_mem [DEPTH];

    logic         w_in_load;
    logic         w_accept;
    logic         w_last_byte;
    logic         w_start;
    logic         w_wr;
    logic [31:0]  w_word;
    logic [31:0]  w_off;
    logic         w_in_range;
    logic         w_unused_ok;

    assign w_in_load   = (r_state == S_HDR) || (r_state == S_DATA);
    assign w_accept    = load_valid_i && w_in_load;
    assign w_last_byte = w_accept && (r_byte_cnt == 2'd3);
    // Earlier bytes sit in r_shift with the first byte lowest: little-endian word.
    assign w_word      = {load_byte_i, r_shift};
    assign w_start     = load_start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_wr        = (r_state == S_DATA) && w_last_byte && (r_rcvd < DEPTH32);

    assign load_ready_o   = w_in_load;
    assign load_busy_o    = w_in_load;
    assign load_done_o    = (r_state == S_DONE);
    assign load_err_o     = r_err;
    assign words_loaded_o = (r_rcvd >= DEPTH32) ? (ADDR_W+1)'(DEPTH) : r_rcvd[ADDR_W:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (load_start_i) w_next = S_HDR;
            S_HDR:  if (w_last_byte)  w_next = (w_word == 32'd0) ? S_DONE : S_DATA;
            S_DATA: if (w_last_byte && (r_rcvd + 32'd1 == r_count)) w_next = S_DONE;
            S_DONE: if (load_start_i) w_next = S_HDR;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
            r_count    <= 32'd0;
            r_rcvd     <= 32'd0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {load_byte_i, r_shift[23:8]};
            if (w_last_byte && (r_state == S_HDR)) begin
                r_count <= w_word;
                if (w_word > DEPTH32) r_err <= 1'b1;
            end
            if (w_last_byte && (r_state == S_DATA)) r_rcvd <= r_rcvd + 32'd1;
        end
    end

    // Array is deliberately not reset so a reset does not wipe a loaded image.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_rcvd[ADDR_W-1:0]] <= w_word;
    end

    assign w_off       = inst_addr_i - BASE_ADDR;
    assign w_in_range  = (w_off[31:ADDR_W+2] == '0);
    assign w_unused_ok = &{1'b0, w_off[1:0]};

    always_comb begin
        inst_o = 32'd0;
        if (inst_en_i) begin
            if (w_in_load)       inst_o = NOP_INST;
            else if (w_in_range) inst_o = r_mem[w_off[ADDR_W+1:2]];
        end
    end
endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: fetch vector table plus hand-written load sessions.
module tb_inst_rom_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 2**ADDR_W;

    logic              clk;
    logic              rst;
    logic              inst_en_i;
    logic [31:0]       inst_addr_i;
    logic [31:0]       inst_o;
    logic              load_start_i;
    logic              load_valid_i;
    logic [7:0]        load_byte_i;
    logic              load_ready_o;
    logic              load_busy_o;
    logic              load_done_o;
    logic              load_err_o;
    logic [ADDR_W:0]   words_loaded_o;

    inst_rom_loader #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_en_i      (inst_en_i),
        .inst_addr_i    (inst_addr_i),
        .inst_o         (inst_o),
        .load_start_i   (load_start_i),
        .load_valid_i   (load_valid_i),
        .load_byte_i    (load_byte_i),
        .load_ready_o   (load_ready_o),
        .load_busy_o    (load_busy_o),
        .load_done_o    (load_done_o),
        .load_err_o     (load_err_o),
        .words_loaded_o (words_loaded_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic [31:0] exp;
        string       name;
    } fetch_vec_t;

    fetch_vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] exp);
        inst_en_i   = 1'b1;
        inst_addr_i = addr;
        #2;
        chk(name, inst_o, exp);
    endtask

    task automatic start_pulse();
        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        load_valid_i = 1'b1;
        load_byte_i  = b;
        k = 0;
        while (!load_ready_o && k < 20) begin
            tick();
            k++;
        end
        if (k == 20) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 20 cycles");
        end
        tick();
        load_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    initial begin
        rst = 1'b1; inst_en_i = 1'b0; inst_addr_i = 32'd0;
        load_start_i = 1'b0; load_valid_i = 1'b0; load_byte_i = 8'd0;
        repeat (3) tick();
        chk("rst_ready", 32'(load_ready_o), 32'd0);
        chk("rst_busy",  32'(load_busy_o),  32'd0);
        chk("rst_done",  32'(load_done_o),  32'd0);
        chk("rst_err",   32'(load_err_o),   32'd0);
        chk("rst_words", 32'(words_loaded_o), 32'd0);
        chk("rst_inst_dis", inst_o, 32'd0);
        rst = 1'b0;
        tick();

        // Basic two-word load
        start_pulse();
        chk("hdr_busy",  32'(load_busy_o),  32'd1);
        chk("hdr_ready", 32'(load_ready_o), 32'd1);
        fetch("hdr_nop", 32'h1c000000, 32'h03400000);
        send_word(32'd2);
        fetch("data_nop", 32'h1c000004, 32'h03400000);
        send_word(32'h02800013);
        chk("t1_words_mid", 32'(words_loaded_o), 32'd1);
        send_word(32'h4c000400);
        chk("t1_done",  32'(load_done_o),  32'd1);
        chk("t1_busy",  32'(load_busy_o),  32'd0);
        chk("t1_ready", 32'(load_ready_o), 32'd0);
        chk("t1_words", 32'(words_loaded_o), 32'd2);

        tbl[0] = '{1'b1, 32'h1c000004, 32'h4c000400, "f_word1"};
        tbl[1] = '{1'b1, 32'h1c000006, 32'h4c000400, "f_word1_lowbits"};
        tbl[2] = '{1'b0, 32'h1c000004, 32'h00000000, "f_disabled"};
        tbl[3] = '{1'b1, 32'h1c000000, 32'h02800013, "f_word0"};
        tbl[4] = '{1'b1, 32'h1c000003, 32'h02800013, "f_word0_lowbits"};
        tbl[5] = '{1'b1, 32'h1bfffffc, 32'h00000000, "f_below_base"};
        tbl[6] = '{1'b1, 32'h1c001000, 32'h00000000, "f_past_end"};
        tbl[7] = '{1'b1, 32'h00000000, 32'h00000000, "f_zero"};
        tbl[8] = '{1'b1, 32'hfffffffc, 32'h00000000, "f_top"};
        for (int i = 0; i < 9; i++) begin
            inst_en_i   = tbl[i].en;
            inst_addr_i = tbl[i].addr;
            #2;
            chk(tbl[i].name, inst_o, tbl[i].exp);
        end

        // Zero-length header
        start_pulse();
        send_word(32'd0);
        chk("t4_done",  32'(load_done_o), 32'd1);
        chk("t4_words", 32'(words_loaded_o), 32'd0);
        fetch("t4_mem0", 32'h1c000000, 32'h02800013);
        fetch("t4_mem1", 32'h1c000004, 32'h4c000400);

        // Oversized header: one word more than the array holds
        start_pulse();
        send_word(DEPTH + 1);
        chk("t5_err_hdr", 32'(load_err_o),  32'd1);
        chk("t5_busy",    32'(load_busy_o), 32'd1);
        for (int i = 0; i < DEPTH; i++) send_word(32'ha5000000 | 32'(i));
        chk("t5_words_full", 32'(words_loaded_o), 32'(DEPTH));
        chk("t5_not_done",   32'(load_done_o), 32'd0);
        send_word(32'hdeadbeef);
        chk("t5_done",  32'(load_done_o), 32'd1);
        chk("t5_words", 32'(words_loaded_o), 32'(DEPTH));
        chk("t5_err",   32'(load_err_o), 32'd1);
        fetch("t5_mem0",    32'h1c000000, 32'ha5000000);
        fetch("t5_mem1",    32'h1c000004, 32'ha5000001);
        fetch("t5_memlast", 32'h1c000ffc, 32'ha50003ff);

        // Reset in the middle of the second data word
        start_pulse();
        chk("t6_err_clr",   32'(load_err_o), 32'd0);
        chk("t6_words_clr", 32'(words_loaded_o), 32'd0);
        send_word(32'd2);
        send_word(32'h44332211);
        send_byte(8'h55);
        send_byte(8'h66);
        tick();
        start_pulse();
        chk("t6_start_ign_words", 32'(words_loaded_o), 32'd1);
        chk("t6_start_ign_busy",  32'(load_busy_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_ready", 32'(load_ready_o), 32'd0);
        chk("t6_busy",  32'(load_busy_o),  32'd0);
        chk("t6_done",  32'(load_done_o),  32'd0);
        chk("t6_words", 32'(words_loaded_o), 32'd0);
        fetch("t6_mem0", 32'h1c000000, 32'h44332211);
        fetch("t6_mem1", 32'h1c000004, 32'ha5000001);

        // Partial word from before reset must not leak into the next header
        start_pulse();
        send_word(32'd1);
        send_word(32'h0badf00d);
        chk("t7_done", 32'(load_done_o), 32'd1);
        fetch("t7_mem0", 32'h1c000000, 32'h0badf00d);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
